// File: rtl/buzzer_arbiter.sv
// Fixed-priority, preemptive arbiter sharing one active-low buzzer between three
// tone sources; generates the PWM, times each note and reports done/abort.
module buzzer_arbiter #(
    parameter int unsigned TICK_CLKS  = 6250000,
    parameter int unsigned GAP_CLKS   = 1000,
    parameter int unsigned DUTY_SHIFT = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req,
    input  logic [19:0] cycle0,
    input  logic [19:0] cycle1,
    input  logic [19:0] cycle2,
    input  logic [7:0]  dur0,
    input  logic [7:0]  dur1,
    input  logic [7:0]  dur2,
    output logic [2:0]  gnt,
    output logic [2:0]  done,
    output logic [2:0]  abort,
    output logic        busy,
    output logic        buzzer
);
    localparam int TW = (TICK_CLKS > 1) ? $clog2(TICK_CLKS) : 1;
    localparam int GW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CLKS - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CLKS - 1);

    typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

    state_t        state_q, state_d;
    logic [1:0]    id_q, id_d;
    logic [2:0]    gnt_q, gnt_d, done_q, done_d, abort_q, abort_d;
    logic [19:0]   cyc_q, cyc_d, hz_cnt_q, hz_cnt_d;
    logic [7:0]    dur_left_q, dur_left_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          buzzer_q, buzzer_d;

    logic [1:0]  win_id;
    logic [19:0] win_cyc;
    logic [7:0]  win_dur;
    logic        higher, cur_req, last;

    always_comb begin
        win_id = req[2] ? 2'd2 : (req[1] ? 2'd1 : 2'd0);
        case (win_id)
            2'd2:    begin win_cyc = cycle2; win_dur = dur2; end
            2'd1:    begin win_cyc = cycle1; win_dur = dur1; end
            default: begin win_cyc = cycle0; win_dur = dur0; end
        endcase
        case (id_q)
            2'd0:    higher = |req[2:1];
            2'd1:    higher = req[2];
            default: higher = 1'b0;
        endcase
        cur_req = req[id_q];
        // dur=0 plays a single clock; otherwise end on the last tick of the last unit
        last = (dur_left_q == 8'd0) || ((dur_left_q == 8'd1) && (tick_cnt_q == TICK_LAST));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req) state_d = TONE;
            TONE:    if (last) state_d = GAP;
                     else if (!higher && !cur_req) state_d = GAP;
            GAP:     if (gap_cnt_q == GAP_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        id_d       = id_q;
        gnt_d      = gnt_q;
        cyc_d      = cyc_q;
        dur_left_d = dur_left_q;
        hz_cnt_d   = hz_cnt_q;
        tick_cnt_d = tick_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        done_d     = 3'b000;
        abort_d    = 3'b000;
        buzzer_d   = 1'b1;
        case (state_q)
            IDLE: ;
            TONE: begin
                // completion outranks preemption; cancel+preempt switches silently
                if (last) begin
                    gnt_d     = 3'b000;
                    done_d    = gnt_q;
                    gap_cnt_d = '0;
                end else if (higher) begin
                    abort_d = cur_req ? gnt_q : 3'b000;
                end else if (!cur_req) begin
                    gnt_d     = 3'b000;
                    gap_cnt_d = '0;
                end else begin
                    if (cyc_q == 20'd0 || hz_cnt_q == cyc_q - 20'd1) hz_cnt_d = 20'd0;
                    else                                              hz_cnt_d = hz_cnt_q + 20'd1;
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        dur_left_d = dur_left_q - 8'd1;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                if (state_d == TONE && hz_cnt_q < (cyc_q >> DUTY_SHIFT)) buzzer_d = 1'b0;
            end
            GAP:     gap_cnt_d = gap_cnt_q + 1'b1;
            default: ;
        endcase
        if ((state_q == IDLE && |req) || (state_q == TONE && !last && higher)) begin
            id_d       = win_id;
            gnt_d      = 3'b001 << win_id;
            cyc_d      = win_cyc;
            dur_left_d = win_dur;
            hz_cnt_d   = 20'd0;
            tick_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q       <= 2'd0;
            gnt_q      <= 3'b000;
            done_q     <= 3'b000;
            abort_q    <= 3'b000;
            cyc_q      <= 20'd0;
            dur_left_q <= 8'd0;
            hz_cnt_q   <= 20'd0;
            tick_cnt_q <= '0;
            gap_cnt_q  <= '0;
            buzzer_q   <= 1'b1;
        end else begin
            id_q       <= id_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
            cyc_q      <= cyc_d;
            dur_left_q <= dur_left_d;
            hz_cnt_q   <= hz_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            buzzer_q   <= buzzer_d;
        end
    end

    assign gnt    = gnt_q;
    assign done   = done_q;
    assign abort  = abort_q;
    assign busy   = (state_q != IDLE);
    assign buzzer = buzzer_q;
endmodule

// File: tb/tb_buzzer_arbiter.sv
// Directed bench for buzzer_arbiter with TICK_CLKS=4, GAP_CLKS=2, DUTY_SHIFT=5.
module tb_buzzer_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req;
    logic [19:0] cycle0, cycle1, cycle2;
    logic [7:0]  dur0, dur1, dur2;
    logic [2:0]  gnt, done, abort;
    logic        busy, buzzer;

    int checks = 0, failures = 0;
    int cyc, viol, bz_low, ndone;
    logic [2:0] prev_gnt, pulses;

    buzzer_arbiter #(.TICK_CLKS(4), .GAP_CLKS(2), .DUTY_SHIFT(5)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .cycle0(cycle0), .cycle1(cycle1), .cycle2(cycle2),
        .dur0(dur0), .dur1(dur1), .dur2(dur2),
        .gnt(gnt), .done(done), .abort(abort), .busy(busy), .buzzer(buzzer)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One clock; samples 1 ns after the edge, tracks pulse sanity, drops req on done.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if ((done & abort) != 3'b000 || (done & ~prev_gnt) != 3'b000 ||
            (abort & ~prev_gnt) != 3'b000) viol++;
        if (!buzzer) bz_low++;
        if (done != 3'b000) ndone++;
        pulses   = pulses | done | abort;
        prev_gnt = gnt;
        req      = req & ~done;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic start();
        cyc = 0; viol = 0; bz_low = 0; ndone = 0; pulses = 3'b000;
    endtask

    initial begin
        rst_n = 1'b0; req = 3'b000; prev_gnt = 3'b000;
        cycle0 = 20'd64; cycle1 = 20'd64; cycle2 = 20'd64;
        dur0 = 8'd1; dur1 = 8'd1; dur2 = 8'd1;
        start();
        #23;
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_buzzer", buzzer, 1);
        chk("rst_pulses", {done, abort}, 0);
        rst_n = 1'b1;
        step(); step();

        // single tone
        cycle0 = 20'd64; dur0 = 8'd2; req = 3'b001; start();
        run_to(1);  chk("t1_gnt_rise", gnt, 3'b001); chk("t1_busy", busy, 1); chk("t1_bz1", buzzer, 1);
        run_to(2);  chk("t1_bz2", buzzer, 0);
        run_to(3);  chk("t1_bz3", buzzer, 0);
        run_to(4);  chk("t1_bz4", buzzer, 1);
        run_to(8);  chk("t1_gnt_last", gnt, 3'b001); chk("t1_nodone", done, 0);
        run_to(9);  chk("t1_gnt_fall", gnt, 0); chk("t1_done", done, 3'b001);
        run_to(10); chk("t1_gap_busy", busy, 1);
        run_to(11); chk("t1_idle", busy, 0); chk("t1_bzlow", bz_low, 2); chk("t1_ndone", ndone, 1);

        // preemption of a long tone
        cycle0 = 20'd100; dur0 = 8'd10; req = 3'b001; start();
        run_to(5);  chk("t2_gnt0", gnt, 3'b001);
        req[2] = 1'b1; cycle2 = 20'd32; dur2 = 8'd1;
        run_to(6);  chk("t2_abort", abort, 3'b001); chk("t2_gnt2", gnt, 3'b100);
        run_to(7);  chk("t2_bz_low", buzzer, 0); chk("t2_abort_once", abort, 0);
        run_to(8);  chk("t2_bz_high", buzzer, 1);
        run_to(9);  chk("t2_gnt2_last", gnt, 3'b100);
        run_to(10); chk("t2_done2", done, 3'b100); chk("t2_gnt_off", gnt, 0);
        run_to(12); chk("t2_idle", busy, 0);
        run_to(13); chk("t2_regrant0", gnt, 3'b001);
        run_to(52); chk("t2_full_tone", gnt, 3'b001);
        run_to(53); chk("t2_done0", done, 3'b001);
        run_to(56); chk("t2_viol", viol, 0);

        // simultaneous requests
        cycle0 = 20'd64; cycle1 = 20'd64; cycle2 = 20'd64;
        dur0 = 8'd1; dur1 = 8'd1; dur2 = 8'd1; req = 3'b111; start();
        run_to(1);  chk("t3_g2", gnt, 3'b100);
        run_to(4);  chk("t3_g2_last", gnt, 3'b100);
        run_to(5);  chk("t3_d2", done, 3'b100);
        run_to(7);  chk("t3_gap", gnt, 0);
        run_to(8);  chk("t3_g1", gnt, 3'b010);
        run_to(12); chk("t3_d1", done, 3'b010);
        run_to(15); chk("t3_g0", gnt, 3'b001);
        run_to(19); chk("t3_d0", done, 3'b001);
        run_to(21); chk("t3_idle", busy, 0); chk("t3_viol", viol, 0); chk("t3_ndone", ndone, 3);

        // rest tone, then zero duration
        cycle1 = 20'd0; dur1 = 8'd3; req = 3'b010; start();
        run_to(12); chk("t4_g1_last", gnt, 3'b010);
        run_to(13); chk("t4_d1", done, 3'b010); chk("t4_silent", bz_low, 0);
        run_to(16);
        cycle0 = 20'd64; dur0 = 8'd0; req = 3'b001; start();
        run_to(1);  chk("t4_g0", gnt, 3'b001);
        run_to(2);  chk("t4_g0_off", gnt, 0); chk("t4_d0", done, 3'b001);
        run_to(5);

        // cancel mid-tone
        dur0 = 8'd10; req = 3'b001; start();
        run_to(4);  req = 3'b000;
        run_to(5);  chk("t5_cancel_gnt", gnt, 0); chk("t5_busy", busy, 1);
        run_to(6);  chk("t5_gap2", busy, 1);
        run_to(7);  chk("t5_idle", busy, 0); chk("t5_nopulse", pulses, 0);

        // reset mid-tone (buzzer is low at this point)
        req = 3'b001; start();
        run_to(3);  chk("t5_bz_before", buzzer, 0);
        rst_n = 1'b0; #1;
        chk("t5_rst_gnt", gnt, 0); chk("t5_rst_busy", busy, 0); chk("t5_rst_bz", buzzer, 1);
        req = 3'b000; #2; rst_n = 1'b1; prev_gnt = 3'b000; start();
        run_to(4);  chk("t5_post_pulses", pulses, 0); chk("t5_post_gnt", gnt, 0);

        // completion collides with preemption
        cycle0 = 20'd64; dur0 = 8'd1; req = 3'b001; start();
        run_to(4);  chk("t6_last", gnt, 3'b001);
        req[2] = 1'b1; dur2 = 8'd1;
        run_to(5);  chk("t6_done0", done, 3'b001); chk("t6_noabort", abort, 0);
        run_to(7);  chk("t6_gap", gnt, 0);
        run_to(8);  chk("t6_g2", gnt, 3'b100);
        run_to(12); chk("t6_d2", done, 3'b100); chk("t6_viol", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
